// File: rtl/host_pkg.sv
// ---------------------------------------------------------------------------
// host_pkg
// Shared definitions for the host register bank:
//   - word addresses of the host-visible registers
//   - bit positions inside the STATUS word
//   - state encoding of the host access FSM
// ---------------------------------------------------------------------------
package host_pkg;

  // Host register map (word addresses)
  localparam int ADDR_ID        = 0;
  localparam int ADDR_CTRL0     = 1;
  localparam int ADDR_CTRL1     = 2;
  localparam int ADDR_STATUS    = 3;
  localparam int ADDR_FIFO_DATA = 4;
  localparam int ADDR_CLEAR     = 5;

  // STATUS word layout
  localparam int STATUS_EMPTY_BIT = 0;
  localparam int STATUS_FULL_BIT  = 1;
  localparam int STATUS_OVF_BIT   = 2;
  localparam int STATUS_COUNT_LSB = 8;
  localparam int STATUS_COUNT_W   = 8;

  // Host access FSM
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_COMMIT = 2'd2
  } access_state_e;

endpackage

// File: rtl/host_fifo.sv
// ---------------------------------------------------------------------------
// host_fifo
// Single-clock FIFO buffering core data words for the host to drain.
//   clk_i    system clock
//   rst_i    asynchronous active-high reset (empties the FIFO)
//   push_i   write strobe; a push into a full FIFO is dropped unless a pop
//            happens in the same cycle
//   pop_i    read strobe; ignored while empty
//   din_i    word to push
//   dout_o   head word, combinational from storage (undefined when empty)
//   count_o  number of stored words, 0..FIFO_DEPTH
//   full_o   registered, tracks count == FIFO_DEPTH
//   empty_o  count == 0
// ---------------------------------------------------------------------------
module host_fifo #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          push_i,
  input  logic                          pop_i,
  input  logic [15:0]                   din_i,
  output logic [15:0]                   dout_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o,
  output logic                          full_o,
  output logic                          empty_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [15:0]      mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wrPtr_q;
  logic [PTR_W-1:0] rdPtr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             full_q;
  logic             doPush;
  logic             doPop;

  assign empty_o = (count_q == '0);
  assign full_o  = full_q;
  assign count_o = count_q;
  assign dout_o  = mem_q[rdPtr_q];

  // A pop frees a slot in the same cycle, so a simultaneous push into a
  // full FIFO is still accepted.
  assign doPop  = pop_i & ~empty_o;
  assign doPush = push_i & (~full_q | doPop);

  always_comb begin
    count_d = count_q;
    if (doPush && !doPop) begin
      count_d = count_q + CNT_W'(1);
    end else if (doPop && !doPush) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Pointers are power-of-two wide, so plain increment wraps modulo depth.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + PTR_W'(1);
      if (doPop)  rdPtr_q <= rdPtr_q + PTR_W'(1);
      count_q <= count_d;
      full_q  <= (count_d == CNT_W'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge clk_i) begin
    if (doPush) mem_q[wrPtr_q] <= din_i;
  end

endmodule

// File: rtl/host_reg_bank.sv
// ---------------------------------------------------------------------------
// host_reg_bank
// Host-facing register bank behind the asynchronous host bus pad stage.
// Synchronises the host strobes, decodes each access against the register
// map, commits writes at access end and buffers core data in a FIFO.
//   CLK, RST       system clock, asynchronous active-high reset
//   nCS/nOE/nWE    asynchronous active-low host strobes
//   Haddr          host word address, stable while nCS is low
//   Hdi            latched host write word
//   Hdo            read word, loaded once per access and then held
//   ctrl0, ctrl1   control registers (ctrl0[0] = interrupt enable)
//   fifo_wr        core push strobe, fifo_din core push word
//   fifo_full      FIFO full
//   irq            interrupt request
// ---------------------------------------------------------------------------
module host_reg_bank #(
  parameter int          ADDR_W     = 4,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [15:0] ID_VALUE   = 16'hE5D1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              nCS,
  input  logic              nOE,
  input  logic              nWE,
  input  logic [ADDR_W-1:0] Haddr,
  input  logic [15:0]       Hdi,
  output logic [15:0]       Hdo,
  output logic [15:0]       ctrl0,
  output logic [15:0]       ctrl1,
  input  logic              fifo_wr,
  input  logic [15:0]       fifo_din,
  output logic              fifo_full,
  output logic              irq
);

  import host_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  // Strobe synchronisers
  logic csMeta_q, csSync_q;
  logic oeMeta_q, oeSync_q;
  logic weMeta_q, weSync_q;
  logic [1:0] syncValid_q;
  logic csPrev_q;
  logic csFall;

  // Access FSM and its datapath
  access_state_e     state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic              firstActive_q;
  logic              weSeen_q;
  logic              oeSeen_q;
  logic              latchAddr;
  logic              loadHdo;
  logic              trackStrobes;
  logic              commitWrite;
  logic              commitPop;

  // Registers
  logic [15:0] hdo_q;
  logic [15:0] ctrl0_q;
  logic [15:0] ctrl1_q;
  logic        overflow_q;
  logic        irq_q;
  logic [15:0] readData;
  logic [15:0] statusWord;
  logic        overflowSet;
  logic        overflowClr;

  // FIFO interface
  logic [15:0]      fifoDout;
  logic [CNT_W-1:0] fifoCount;
  logic             fifoFull;
  logic             fifoEmpty;

  assign Hdo       = hdo_q;
  assign ctrl0     = ctrl0_q;
  assign ctrl1     = ctrl1_q;
  assign fifo_full = fifoFull;
  assign irq       = irq_q;

  // Two-flop synchronisers; they reset to the idle-high level.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      csMeta_q <= 1'b1;
      csSync_q <= 1'b1;
      oeMeta_q <= 1'b1;
      oeSync_q <= 1'b1;
      weMeta_q <= 1'b1;
      weSync_q <= 1'b1;
    end else begin
      csMeta_q <= nCS;
      csSync_q <= csMeta_q;
      oeMeta_q <= nOE;
      oeSync_q <= oeMeta_q;
      weMeta_q <= nWE;
      weSync_q <= weMeta_q;
    end
  end

  // The synchroniser outputs only reflect the real pins once the reset
  // value has flushed through. csPrev_q stays low until a genuine high
  // level has been observed, so an access already in progress when reset
  // releases never produces a falling edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      syncValid_q <= 2'b00;
      csPrev_q    <= 1'b0;
    end else begin
      syncValid_q <= {syncValid_q[0], 1'b1};
      csPrev_q    <= syncValid_q[1] ? csSync_q : 1'b0;
    end
  end

  assign csFall = csPrev_q & ~csSync_q;

  // FSM state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (csFall)   state_d = ST_ACTIVE;
      ST_ACTIVE: if (csSync_q) state_d = ST_COMMIT;
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    latchAddr    = 1'b0;
    loadHdo      = 1'b0;
    trackStrobes = 1'b0;
    commitWrite  = 1'b0;
    commitPop    = 1'b0;
    case (state_q)
      ST_IDLE: latchAddr = csFall;
      ST_ACTIVE: begin
        loadHdo      = firstActive_q;
        trackStrobes = 1'b1;
      end
      ST_COMMIT: begin
        commitWrite = weSeen_q;
        commitPop   = ~weSeen_q & oeSeen_q &
                      (addr_q == ADDR_W'(ADDR_FIFO_DATA));
      end
      default: ;
    endcase
  end

  // Access address and strobe history
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      addr_q        <= '0;
      firstActive_q <= 1'b0;
      weSeen_q      <= 1'b0;
      oeSeen_q      <= 1'b0;
    end else begin
      firstActive_q <= latchAddr;
      if (latchAddr) begin
        addr_q   <= Haddr;
        weSeen_q <= 1'b0;
        oeSeen_q <= 1'b0;
      end else if (trackStrobes) begin
        weSeen_q <= weSeen_q | ~weSync_q;
        oeSeen_q <= oeSeen_q | ~oeSync_q;
      end
    end
  end

  always_comb begin
    statusWord = '0;
    statusWord[STATUS_COUNT_LSB +: STATUS_COUNT_W] = STATUS_COUNT_W'(fifoCount);
    statusWord[STATUS_OVF_BIT]   = overflow_q;
    statusWord[STATUS_FULL_BIT]  = fifoFull;
    statusWord[STATUS_EMPTY_BIT] = fifoEmpty;
  end

  always_comb begin
    readData = '0;
    case (addr_q)
      ADDR_W'(ADDR_ID):        readData = ID_VALUE;
      ADDR_W'(ADDR_CTRL0):     readData = ctrl0_q;
      ADDR_W'(ADDR_CTRL1):     readData = ctrl1_q;
      ADDR_W'(ADDR_STATUS):    readData = statusWord;
      ADDR_W'(ADDR_FIFO_DATA): readData = fifoEmpty ? 16'h0000 : fifoDout;
      default:                 readData = '0;
    endcase
  end

  // A push is dropped only when full and no pop frees a slot that cycle.
  assign overflowSet = fifo_wr & fifoFull & ~commitPop;
  assign overflowClr = commitWrite & (addr_q == ADDR_W'(ADDR_CLEAR)) & Hdi[0];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hdo_q      <= '0;
      ctrl0_q    <= '0;
      ctrl1_q    <= '0;
      overflow_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      if (loadHdo) hdo_q <= readData;
      if (commitWrite && addr_q == ADDR_W'(ADDR_CTRL0)) ctrl0_q <= Hdi;
      if (commitWrite && addr_q == ADDR_W'(ADDR_CTRL1)) ctrl1_q <= Hdi;
      if (overflowSet)      overflow_q <= 1'b1;
      else if (overflowClr) overflow_q <= 1'b0;
      irq_q <= ctrl0_q[0] & (~fifoEmpty | overflow_q);
    end
  end

  host_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (CLK),
    .rst_i  (RST),
    .push_i (fifo_wr),
    .pop_i  (commitPop),
    .din_i  (fifo_din),
    .dout_o (fifoDout),
    .count_o(fifoCount),
    .full_o (fifoFull),
    .empty_o(fifoEmpty)
  );

endmodule

// File: tb/tb_host_reg_bank.sv
// ---------------------------------------------------------------------------
// tb_host_reg_bank
// Directed bench for host_reg_bank: host reads/writes through the strobe
// synchronisers, FIFO fill/drain, overflow and clear, interrupt behaviour
// and reset in the middle of an access.
// ---------------------------------------------------------------------------
module tb_host_reg_bank;

  logic        CLK = 1'b0;
  logic        RST;
  logic        nCS;
  logic        nOE;
  logic        nWE;
  logic [3:0]  Haddr;
  logic [15:0] Hdi;
  logic [15:0] Hdo;
  logic [15:0] ctrl0;
  logic [15:0] ctrl1;
  logic        fifo_wr;
  logic [15:0] fifo_din;
  logic        fifo_full;
  logic        irq;

  int vectors     = 0;
  int miscompares = 0;

  logic [15:0] rd;

  host_reg_bank #(
    .ADDR_W    (4),
    .FIFO_DEPTH(16),
    .ID_VALUE  (16'hE5D1)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .nCS      (nCS),
    .nOE      (nOE),
    .nWE      (nWE),
    .Haddr    (Haddr),
    .Hdi      (Hdi),
    .Hdo      (Hdo),
    .ctrl0    (ctrl0),
    .ctrl1    (ctrl1),
    .fifo_wr  (fifo_wr),
    .fifo_din (fifo_din),
    .fifo_full(fifo_full),
    .irq      (irq)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%04h expected 0x%04h", tag, observed, expected);
    end
  endtask

  // One host access on the falling clock edge. nCS is held low for 5 CLK,
  // Hdo is sampled 4 CLK after the nCS fall. With pushAtCommit the core
  // pushes exactly on the commit cycle. Returns 4 CLK after the nCS rise.
  task automatic applyStimulus(input logic isWrite, input logic [3:0] addr,
                               input logic [15:0] wdata, input logic pushAtCommit,
                               input logic [15:0] pushData, output logic [15:0] rdata);
    repeat (2) @(negedge CLK);
    Haddr = addr;
    Hdi   = wdata;
    nCS   = 1'b0;
    nOE   = isWrite;
    nWE   = ~isWrite;
    repeat (4) @(negedge CLK);
    rdata = Hdo;
    @(negedge CLK);
    nCS = 1'b1;
    nOE = 1'b1;
    nWE = 1'b1;
    if (pushAtCommit) begin
      repeat (3) @(negedge CLK);
      fifo_wr  = 1'b1;
      fifo_din = pushData;
      @(negedge CLK);
      fifo_wr  = 1'b0;
    end else begin
      repeat (4) @(negedge CLK);
    end
  endtask

  task automatic pushWords(input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) begin
      fifo_wr  = 1'b1;
      fifo_din = base + 16'(i);
      @(negedge CLK);
    end
    fifo_wr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] simulation timed out");
  end

  initial begin
    RST = 1'b1; nCS = 1'b1; nOE = 1'b1; nWE = 1'b1;
    Haddr = '0; Hdi = '0; fifo_wr = 1'b0; fifo_din = '0;
    repeat (3) @(negedge CLK);
    checkOutput("rst_hdo",   Hdo, 16'h0000);
    checkOutput("rst_ctrl0", ctrl0, 16'h0000);
    checkOutput("rst_ctrl1", ctrl1, 16'h0000);
    checkOutput("rst_full",  {15'd0, fifo_full}, 16'h0000);
    checkOutput("rst_irq",   {15'd0, irq}, 16'h0000);
    RST = 1'b0;
    repeat (4) @(negedge CLK);

    // ID read, unmapped read, write to a read-only register
    applyStimulus(1'b0, 4'd0, 16'h0, 1'b0, 16'h0, rd);
    checkOutput("id_read", rd, 16'hE5D1);
    checkOutput("id_irq", {15'd0, irq}, 16'h0000);
    applyStimulus(1'b0, 4'd9, 16'h0, 1'b0, 16'h0, rd);
    checkOutput("unmapped_read", rd, 16'h0000);
    applyStimulus(1'b1, 4'd0, 16'hFFFF, 1'b0, 16'h0, rd);
    applyStimulus(1'b0, 4'd0, 16'h0, 1'b0, 16'h0, rd);
    checkOutput("id_after_write", rd, 16'hE5D1);

    // CTRL1 write and readback
    applyStimulus(1'b1, 4'd2, 16'h1234, 1'b0, 16'h0, rd);
    checkOutput("ctrl1_port", ctrl1, 16'h1234);
    checkOutput("ctrl0_untouched", ctrl0, 16'h0000);
    applyStimulus(1'b0, 4'd2, 16'h0, 1'b0, 16'h0, rd);
    checkOutput("ctrl1_read", rd, 16'h1234);

    // FIFO fill and drain
    pushWords(3, 16'hA001);
    applyStimulus(1'b0, 4'd3, 16'h0, 1'b0, 16'h0, rd);
    checkOutput("status_3", rd, 16'h0300);
    applyStimulus(1'b0, 4'd4, 16'h0, 1'b0, 16'h0, rd);
    checkOutput("pop_1", rd, 16'hA001);
    applyStimulus(1'b0, 4'd4, 16'h0, 1'b0, 16'h0, rd);
    checkOutput("pop_2", rd, 16'hA002);
    applyStimulus(1'b0, 4'd4, 16'h0, 1'b0, 16'h0, rd);
    checkOutput("pop_3", rd, 16'hA003);
    applyStimulus(1'b0, 4'd3, 16'h0, 1'b0, 16'h0, rd);
    checkOutput("status_empty", rd, 16'h0001);
    applyStimulus(1'b0, 4'd4, 16'h0, 1'b0, 16'h0, rd);
    checkOutput("pop_empty", rd, 16'h0000);
    applyStimulus(1'b0, 4'd3, 16'h0, 1'b0, 16'h0, rd);
    checkOutput("status_still_empty", rd, 16'h0001);

    // Interrupt: enable, push one word, pop it
    applyStimulus(1'b1, 4'd1, 16'h0001, 1'b0, 16'h0, rd);
    checkOutput("ctrl0_port", ctrl0, 16'h0001);
    checkOutput("irq_idle", {15'd0, irq}, 16'h0000);
    pushWords(1, 16'hB001);
    @(negedge CLK);
    checkOutput("irq_set", {15'd0, irq}, 16'h0001);
    applyStimulus(1'b0, 4'd4, 16'h0, 1'b0, 16'h0, rd);
    checkOutput("irq_pop_data", rd, 16'hB001);
    repeat (2) @(negedge CLK);
    checkOutput("irq_clear", {15'd0, irq}, 16'h0000);

    // Overflow: 17 pushes into a 16-deep FIFO, then clear
    pushWords(17, 16'hC000);
    @(negedge CLK);
    checkOutput("full_flag", {15'd0, fifo_full}, 16'h0001);
    checkOutput("irq_overflow", {15'd0, irq}, 16'h0001);
    applyStimulus(1'b0, 4'd3, 16'h0, 1'b0, 16'h0, rd);
    checkOutput("status_ovf", rd, 16'h1006);
    applyStimulus(1'b1, 4'd5, 16'h0001, 1'b0, 16'h0, rd);
    applyStimulus(1'b0, 4'd3, 16'h0, 1'b0, 16'h0, rd);
    checkOutput("status_cleared", rd, 16'h1002);
    applyStimulus(1'b0, 4'd5, 16'h0, 1'b0, 16'h0, rd);
    checkOutput("clear_reads_zero", rd, 16'h0000);

    // Push and pop on the same cycle while full
    applyStimulus(1'b0, 4'd4, 16'h0, 1'b1, 16'hD000, rd);
    checkOutput("full_pop_data", rd, 16'hC000);
    checkOutput("full_kept", {15'd0, fifo_full}, 16'h0001);
    applyStimulus(1'b0, 4'd3, 16'h0, 1'b0, 16'h0, rd);
    checkOutput("status_push_pop", rd, 16'h1002);
    applyStimulus(1'b0, 4'd4, 16'h0, 1'b0, 16'h0, rd);
    checkOutput("next_head", rd, 16'hC001);

    // Reset in the middle of a FIFO_DATA read
    repeat (2) @(negedge CLK);
    Haddr = 4'd4;
    nCS   = 1'b0;
    nOE   = 1'b0;
    repeat (5) @(negedge CLK);
    checkOutput("pre_rst_hdo", Hdo, 16'hC002);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    checkOutput("midrst_hdo",   Hdo, 16'h0000);
    checkOutput("midrst_ctrl0", ctrl0, 16'h0000);
    checkOutput("midrst_full",  {15'd0, fifo_full}, 16'h0000);
    checkOutput("midrst_irq",   {15'd0, irq}, 16'h0000);
    RST = 1'b0;
    pushWords(1, 16'hE001);
    repeat (6) @(negedge CLK);
    nCS = 1'b1;
    nOE = 1'b1;
    repeat (6) @(negedge CLK);
    checkOutput("post_rst_hdo", Hdo, 16'h0000);
    applyStimulus(1'b0, 4'd3, 16'h0, 1'b0, 16'h0, rd);
    checkOutput("post_rst_status", rd, 16'h0100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
